// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - instruction store with built-in boot image, combinational read, load-write port
module instruction_memory #(
  parameter int          DEPTH    = 256,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  output logic [31:0] instruction,
  output logic        addr_error,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [31:0] mem_t [DEPTH];

  localparam mem_t BOOT_IMAGE = '{
    0:       32'h00500093,
    1:       32'h00A00113,
    2:       32'h002081B3,
    3:       32'h00000013,
    default: NOP_WORD
  };

  // The declaration initialiser makes the boot image readable before any reset.
  mem_t mem = BOOT_IMAGE;

  logic rd_in_range;
  logic wr_in_range;

  assign rd_in_range = (address < 32'(DEPTH));
  assign wr_in_range = (wr_addr < 32'(DEPTH));

  assign addr_error  = ~rd_in_range;
  assign instruction = rd_in_range ? mem[address[AW-1:0]] : NOP_WORD;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= BOOT_IMAGE;
    end else if (wr_en && wr_in_range) begin
      mem[wr_addr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// tb/tb_instruction_memory.sv - directed and randomized checks of instruction_memory against a reference array
module tb_instruction_memory;

  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] instruction;
  logic        addr_error;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [DEPTH];

  instruction_memory #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .instruction (instruction),
    .addr_error  (addr_error),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] boot_word(int i);
    case (i)
      0:       return 32'h00500093;
      1:       return 32'h00A00113;
      2:       return 32'h002081B3;
      default: return NOP;
    endcase
  endfunction

  task automatic model_boot();
    for (int i = 0; i < DEPTH; i++) model[i] = boot_word(i);
  endtask

  function automatic logic [31:0] model_read(logic [31:0] a);
    if (a < DEPTH) return model[a];
    return NOP;
  endfunction

  task automatic model_edge(logic rst, logic we, logic [31:0] wa, logic [31:0] wd);
    if (rst) model_boot();
    else if (we && wa < DEPTH) model[wa] = wd;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] a);
    address = a;
    #1;
    chk({tag, "_instr"}, instruction, model_read(a));
    chk({tag, "_aerr"}, {31'b0, addr_error}, {31'b0, (a >= DEPTH)});
  endtask

  task automatic edge_step(input logic rst, input logic we, input logic [31:0] wa, input logic [31:0] wd);
    reset   = rst;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    @(posedge clk);
    model_edge(rst, we, wa, wd);
    #1;
    reset = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    logic        r_rst, r_we;
    logic [31:0] r_wa, r_wd, r_ra;

    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    address = '0;
    model_boot();

    // Boot image must be visible before the first clock edge and before reset.
    rd("pre_reset_w0", 32'd0);
    rd("pre_reset_w1", 32'd1);
    rd("pre_reset_w2", 32'd2);

    edge_step(1'b1, 1'b0, 32'd0, 32'd0);

    address = 32'd0; #10;
    chk("boot_w0", instruction, 32'h00500093);
    chk("boot_w0_aerr", {31'b0, addr_error}, 32'd0);
    address = 32'd1; #10;
    chk("boot_w1", instruction, 32'h00A00113);
    address = 32'd2; #10;
    chk("boot_w2", instruction, 32'h002081B3);
    address = 32'd3; #1;
    chk("boot_w3", instruction, 32'h00000013);
    address = DEPTH - 1; #1;
    chk("last_word", instruction, 32'h00000013);
    chk("last_word_aerr", {31'b0, addr_error}, 32'd0);
    address = DEPTH; #1;
    chk("depth_instr", instruction, 32'h00000013);
    chk("depth_aerr", {31'b0, addr_error}, 32'd1);
    address = 32'hFFFFFFFF; #1;
    chk("max_instr", instruction, 32'h00000013);
    chk("max_aerr", {31'b0, addr_error}, 32'd1);

    // Same-cycle write and read: old word before the edge, new word after.
    address = 32'd5;
    wr_en = 1'b1; wr_addr = 32'd5; wr_data = 32'hDEADBEEF;
    #1;
    chk("wr5_before", instruction, 32'h00000013);
    @(posedge clk);
    model_edge(1'b0, 1'b1, 32'd5, 32'hDEADBEEF);
    #1;
    wr_en = 1'b0;
    chk("wr5_after", instruction, 32'hDEADBEEF);

    edge_step(1'b0, 1'b1, 32'd1, 32'h12345678);
    rd("wr1", 32'd1);
    chk("wr1_const", instruction, 32'h12345678);
    edge_step(1'b1, 1'b1, 32'd2, 32'hCAFEF00D);
    address = 32'd1; #1;
    chk("rst_w1", instruction, 32'h00A00113);
    address = 32'd2; #1;
    chk("rst_w2", instruction, 32'h002081B3);
    address = 32'd5; #1;
    chk("rst_w5", instruction, 32'h00000013);

    // Out-of-range write must not alias into the array.
    edge_step(1'b0, 1'b1, DEPTH + 3, 32'hBADBAD00);
    for (int i = 0; i < DEPTH; i++) begin
      address = i;
      #1;
      checks++;
      assert (instruction === boot_word(i)) else begin
        failures++;
        $error("FAIL oor_readback word=%0d observed=%h expected=%h", i, instruction, boot_word(i));
      end
    end

    for (int n = 0; n < 300; n++) begin
      r_rst = ($urandom_range(0, 39) == 0);
      r_we  = $urandom_range(0, 1);
      r_wa  = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, DEPTH + 15);
      r_wd  = $urandom;
      r_ra  = ($urandom_range(0, 3) == 0) ? r_wa :
              (($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, DEPTH + 15));
      reset = r_rst; wr_en = r_we; wr_addr = r_wa; wr_data = r_wd;
      rd("rand_pre", r_ra);
      @(posedge clk);
      model_edge(r_rst, r_we, r_wa, r_wd);
      #1;
      reset = 1'b0; wr_en = 1'b0;
      rd("rand_post", r_ra);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
